// File: rtl/tia_hsync_controller.sv
// ---------------------------------------------------------------------------
// tia_hsync_controller
//
// Horizontal timing generator for a TIA-style video chip. A 2-bit phase
// counter divides the colour clock by four; every fourth clock a 6-bit LFSR
// (hcount) advances one count. A line is 57 counts (228 clk). The line
// position is decoded into registered sync/blank/centre strobes, and a
// WSYNC halt holds the CPU ready line low until the next line start.
//
// Ports
//   clk        in   master colour clock, all state changes on posedge
//   reset      in   asynchronous active-low reset
//   wsync      in   one-clk strobe: halt CPU (rdy low) until next line start
//   rsync      in   one-clk strobe: restart the line immediately
//   hmove      in   one-clk strobe: extend this line's hblank by two counts
//   hcount     out  [5:0] current horizontal LFSR state
//   phase      out  [1:0] clock phase within a count, 0..3
//   hsync      out  horizontal sync, counts 4..7
//   hblank     out  horizontal blank, counts 0..15 (0..17 after hmove)
//   center     out  high for the whole of count 36
//   line_start out  one-clk pulse marking entry to count 0
//   rdy        out  CPU ready, low while a WSYNC halt is pending
// ---------------------------------------------------------------------------
module tia_hsync_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       wsync,
  input  logic       rsync,
  input  logic       hmove,
  output logic [5:0] hcount,
  output logic [1:0] phase,
  output logic       hsync,
  output logic       hblank,
  output logic       center,
  output logic       line_start,
  output logic       rdy
);

  // One LFSR advance: shift right, feed back cur[1] XNOR-style into bit 5.
  function automatic logic [5:0] lfsr_next(input logic [5:0] cur);
    return {cur[1] ^ ~cur[0], cur[5:1]};
  endfunction

  // Pattern reached after k advances from zero; used only at elaboration
  // so the decode constants stay tied to the feedback rule above.
  function automatic logic [5:0] lfsr_pattern(input int k);
    logic [5:0] p;
    p = 6'b000000;
    for (int i = 0; i < k; i++) begin
      p = lfsr_next(p);
    end
    return p;
  endfunction

  localparam logic [5:0] PAT_LAST        = lfsr_pattern(56);
  localparam logic [5:0] PAT_HSYNC_ON    = lfsr_pattern(4);
  localparam logic [5:0] PAT_HSYNC_OFF   = lfsr_pattern(8);
  localparam logic [5:0] PAT_HBLANK_OFF  = lfsr_pattern(16);
  localparam logic [5:0] PAT_LATE_HB_OFF = lfsr_pattern(18);
  localparam logic [5:0] PAT_CENTER      = lfsr_pattern(36);

  logic       late_hb;
  logic       advance;
  logic       restart;
  logic       step;
  logic       late_next;
  logic [5:0] next_count;

  // restart covers both the natural wrap and a forced rsync; rsync wins over
  // any advance that would have happened on the same edge. hmove on a restart
  // edge survives the clear so it applies to the new line.
  always_comb begin
    advance    = (phase == 2'd3);
    restart    = rsync | (advance & (hcount == PAT_LAST));
    step       = rsync | advance;
    next_count = restart ? 6'b000000 : lfsr_next(hcount);
    late_next  = restart ? hmove : (late_hb | hmove);
  end

  // All outputs are registered and describe the count being entered on the
  // edge. hsync/hblank are set/clear flops keyed on the entered pattern, so
  // a late hmove after blanking has ended cannot bring hblank back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= 2'd0;
      hcount     <= 6'b000000;
      late_hb    <= 1'b0;
      line_start <= 1'b0;
      rdy        <= 1'b1;
      hsync      <= 1'b0;
      hblank     <= 1'b1;
      center     <= 1'b0;
    end else begin
      phase      <= rsync ? 2'd0 : phase + 2'd1;
      late_hb    <= late_next;
      line_start <= restart;
      // A wsync coinciding with the release edge re-arms the halt.
      rdy        <= restart ? ~wsync : (rdy & ~wsync);
      if (step) begin
        hcount <= next_count;
        center <= (next_count == PAT_CENTER);
        if (restart) begin
          hsync  <= 1'b0;
          hblank <= 1'b1;
        end else begin
          if (next_count == PAT_HSYNC_ON) begin
            hsync <= 1'b1;
          end else if (next_count == PAT_HSYNC_OFF) begin
            hsync <= 1'b0;
          end
          if (next_count == PAT_HBLANK_OFF) begin
            hblank <= late_next;
          end else if (next_count == PAT_LATE_HB_OFF) begin
            hblank <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tia_hsync_controller.sv
// ---------------------------------------------------------------------------
// tb_tia_hsync_controller
//
// Self-checking bench for tia_hsync_controller. A behavioural model tracks
// the line position as a plain count index (0..56) and phase, and derives
// every output from the line-timing rules; the LFSR pattern for a count is
// computed by iterating the advance rule. Directed scenarios steer the line
// to the interesting positions, then a randomized run mixes all strobes.
// ---------------------------------------------------------------------------
module tb_tia_hsync_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       wsync;
  logic       rsync;
  logic       hmove;
  logic [5:0] hcount;
  logic [1:0] phase;
  logic       hsync;
  logic       hblank;
  logic       center;
  logic       line_start;
  logic       rdy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mK;
  int mPh;
  bit mLate;
  bit mHalt;
  bit mLine;
  bit mHs;
  bit mHb;
  bit mCtr;

  // Line measurements taken from observed DUT outputs
  int sinceStart = 0;
  int hbCnt      = 0;
  int lastPeriod = 0;
  int lastHb     = 0;
  int lineSeen   = 0;

  always #5 clk = ~clk;

  tia_hsync_controller dut (
    .clk        (clk),
    .reset      (reset),
    .wsync      (wsync),
    .rsync      (rsync),
    .hmove      (hmove),
    .hcount     (hcount),
    .phase      (phase),
    .hsync      (hsync),
    .hblank     (hblank),
    .center     (center),
    .line_start (line_start),
    .rdy        (rdy)
  );

  // LFSR pattern after k advances from all-zeros.
  function automatic logic [5:0] patternOf(input int k);
    logic [5:0] p;
    logic       fb;
    p = 6'b000000;
    for (int i = 0; i < k; i++) begin
      fb   = p[1] ^ ~p[0];
      p    = p >> 1;
      p[5] = fb;
    end
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    mK    = 0;
    mPh   = 0;
    mLate = 1'b0;
    mHalt = 1'b0;
    mLine = 1'b0;
    mHs   = 1'b0;
    mHb   = 1'b1;
    mCtr  = 1'b0;
  endtask

  // One clock edge of the line-timing rules.
  task automatic modelStep(input bit w, input bit r, input bit m);
    bit restart;
    bit adv;
    restart = 1'b0;
    adv     = 1'b0;
    if (r) begin
      mK      = 0;
      mPh     = 0;
      restart = 1'b1;
    end else begin
      if (mPh == 3) begin
        adv = 1'b1;
        if (mK == 56) begin
          mK      = 0;
          restart = 1'b1;
        end else begin
          mK = mK + 1;
        end
      end
      mPh = (mPh + 1) % 4;
    end
    mLate = restart ? m : (mLate | m);
    mHalt = restart ? w : (mHalt | w);
    mLine = restart;
    if (restart || adv) begin
      mHs  = (mK >= 4) && (mK <= 7);
      mCtr = (mK == 36);
      mHb  = (mK < 16) || ((mK < 18) && mLate && mHb);
    end
  endtask

  task automatic compareAll();
    checkOutput("hcount", hcount, patternOf(mK));
    checkOutput("phase", phase, mPh);
    checkOutput("hsync", hsync, mHs);
    checkOutput("hblank", hblank, mHb);
    checkOutput("center", center, mCtr);
    checkOutput("line_start", line_start, mLine);
    checkOutput("rdy", rdy, !mHalt);
  endtask

  // Drive strobes for one edge, advance the model, check, and update the
  // per-line measurements from the observed outputs.
  task automatic applyStimulus(input bit w, input bit r, input bit m);
    wsync = w;
    rsync = r;
    hmove = m;
    @(posedge clk);
    modelStep(w, r, m);
    #1;
    wsync = 1'b0;
    rsync = 1'b0;
    hmove = 1'b0;
    compareAll();
    sinceStart++;
    if (line_start) begin
      lastPeriod = sinceStart;
      lastHb     = hbCnt;
      sinceStart = 0;
      hbCnt      = hblank ? 1 : 0;
      lineSeen++;
    end else begin
      hbCnt = hbCnt + (hblank ? 1 : 0);
    end
  endtask

  // Reset is asserted between edges so the async clear is visible at once.
  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    repeat (3) @(posedge clk);
    #1;
    compareAll();
    reset      = 1'b1;
    sinceStart = 0;
    hbCnt      = 1;
  endtask

  task automatic runTo(input int tk, input int tp);
    int n;
    n = 0;
    while (!(mK == tk && mPh == tp) && n < 400) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("runTo_reached", (mK == tk && mPh == tp), 1'b1);
  endtask

  task automatic runLines(input int count);
    int target;
    int n;
    target = lineSeen + count;
    n      = 0;
    while (lineSeen < target && n < count * 240) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("line_wait", lineSeen, target);
  endtask

  initial begin
    reset = 1'b1;
    wsync = 1'b0;
    rsync = 1'b0;
    hmove = 1'b0;
    #2;
    doReset();

    // Free-running lines straight out of reset
    runLines(1);
    checkOutput("first_period", lastPeriod, 228);
    for (int i = 0; i < 2; i++) begin
      runLines(1);
      checkOutput("free_period", lastPeriod, 228);
      checkOutput("free_hblank_len", lastHb, 64);
    end

    // WSYNC mid-line, then WSYNC on the wrap edge
    runTo(20, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runLines(1);
    checkOutput("wsync_release_rdy", rdy, 1'b1);
    runTo(56, 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wsync_on_wrap_rdy", rdy, 1'b0);
    runTo(30, 0);
    checkOutput("wsync_held_midline", rdy, 1'b0);
    runLines(1);
    checkOutput("wsync_wrap_release", rdy, 1'b1);

    // HMOVE mid-blank, then HMOVE on the wrap edge
    runTo(2, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runLines(1);
    checkOutput("hmove_hblank_len", lastHb, 72);
    runLines(1);
    checkOutput("after_hmove_hblank_len", lastHb, 64);
    runTo(56, 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runLines(1);
    checkOutput("hmove_wrap_hblank_len", lastHb, 72);

    // RSYNC at count 30 phase 2 while halted
    runTo(20, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTo(30, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rsync_line_start", line_start, 1'b1);
    checkOutput("rsync_rdy_release", rdy, 1'b1);
    runLines(1);
    checkOutput("rsync_period", lastPeriod, 228);

    // Reset in the middle of a halt
    runTo(25, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTo(40, 0);
    doReset();
    runLines(1);
    checkOutput("reset_period", lastPeriod, 228);

    // Randomized mix of all strobes with occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1999) == 0) begin
        doReset();
      end
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 399) == 0,
                    $urandom_range(0, 47) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
